// File: rtl/somador_sinal_pipeline.sv
// Two-stage flow-controlled adder for mixed-sign operands with an optional running
// accumulator; overflow either clamps to the result range or wraps, chosen by SATURAR.
module somador_sinal_pipeline #(
    parameter int LARG_A  = 8,
    parameter int LARG_B  = 4,
    parameter int LARG_S  = 8,
    parameter int SATURAR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              entrada_valida,
    output logic              entrada_pronta,
    input  logic [LARG_A-1:0] entrada_a,
    input  logic [LARG_B-1:0] entrada_b,
    input  logic [2:0]        codigo,
    input  logic              limpar_acc,
    output logic [LARG_S-1:0] saida,
    output logic              estouro,
    output logic              saida_valida,
    input  logic              saida_pronta
);

    localparam int LARG_AB = (LARG_A > LARG_B) ? LARG_A : LARG_B;
    localparam int LARG_M  = (LARG_AB > LARG_S) ? LARG_AB : LARG_S;
    localparam int W       = LARG_M + 2;
    // One extra bit so that A + B + acc can never wrap inside the adder itself.
    localparam int SOMA_W  = W + 1;

    localparam logic signed [SOMA_W-1:0] MAX_U = {{(SOMA_W-LARG_S){1'b0}}, {LARG_S{1'b1}}};
    localparam logic signed [SOMA_W-1:0] MAX_S = {{(SOMA_W-LARG_S+1){1'b0}}, {(LARG_S-1){1'b1}}};
    localparam logic signed [SOMA_W-1:0] MIN_S = {{(SOMA_W-LARG_S+1){1'b1}}, {(LARG_S-1){1'b0}}};

    function automatic logic signed [W-1:0] estende_a(input logic [LARG_A-1:0] v, input logic sinal);
        return sinal ? {{(W-LARG_A){v[LARG_A-1]}}, v} : {{(W-LARG_A){1'b0}}, v};
    endfunction

    function automatic logic signed [W-1:0] estende_b(input logic [LARG_B-1:0] v, input logic sinal);
        return sinal ? {{(W-LARG_B){v[LARG_B-1]}}, v} : {{(W-LARG_B){1'b0}}, v};
    endfunction

    // Returns {overflow, result}; the range depends on whether the result type is signed.
    function automatic logic [LARG_S:0] satura(input logic signed [SOMA_W-1:0] e, input logic sinal);
        logic                ovf;
        logic [LARG_S-1:0]   v;
        ovf = 1'b0;
        v   = e[LARG_S-1:0];
        if (sinal) begin
            if (e > MAX_S) begin
                ovf = 1'b1;
                if (SATURAR != 0) v = MAX_S[LARG_S-1:0];
            end else if (e < MIN_S) begin
                ovf = 1'b1;
                if (SATURAR != 0) v = MIN_S[LARG_S-1:0];
            end
        end else begin
            if (e[SOMA_W-1]) begin
                ovf = 1'b1;
                if (SATURAR != 0) v = '0;
            end else if (e > MAX_U) begin
                ovf = 1'b1;
                if (SATURAR != 0) v = MAX_U[LARG_S-1:0];
            end
        end
        return {ovf, v};
    endfunction

    logic                     avancar;
    logic signed [W-1:0]      ext_a_p0;
    logic signed [W-1:0]      ext_b_p0;

    logic                     vld_p1;
    logic signed [W-1:0]      ext_a_p1;
    logic signed [W-1:0]      ext_b_p1;
    logic [2:0]               codigo_p1;

    logic                     sinal_res_p1;
    logic signed [SOMA_W-1:0] acc_ext_p1;
    logic signed [SOMA_W-1:0] soma_p1;
    logic [LARG_S:0]          resultado_p1;

    logic                     vld_p2;
    logic [LARG_S-1:0]        saida_p2;
    logic                     estouro_p2;
    logic [LARG_S-1:0]        acc_p2;

    assign avancar        = !vld_p2 || saida_pronta;
    assign entrada_pronta = avancar;
    assign saida          = saida_p2;
    assign estouro        = estouro_p2;
    assign saida_valida   = vld_p2;

    // Stage 0 -> 1: operand extension and registration
    assign ext_a_p0 = estende_a(entrada_a, codigo[0]);
    assign ext_b_p0 = estende_b(entrada_b, codigo[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            ext_a_p1  <= '0;
            ext_b_p1  <= '0;
            codigo_p1 <= '0;
        end else if (avancar) begin
            vld_p1    <= entrada_valida;
            ext_a_p1  <= ext_a_p0;
            ext_b_p1  <= ext_b_p0;
            codigo_p1 <= codigo;
        end
    end

    // Stage 1 -> 2: exact sum with accumulator, range check, result register
    always_comb begin
        sinal_res_p1 = |codigo_p1[1:0];
        acc_ext_p1   = '0;
        if (codigo_p1[2]) begin
            acc_ext_p1 = sinal_res_p1 ? {{(SOMA_W-LARG_S){acc_p2[LARG_S-1]}}, acc_p2}
                                      : {{(SOMA_W-LARG_S){1'b0}}, acc_p2};
        end
        soma_p1      = {ext_a_p1[W-1], ext_a_p1} + {ext_b_p1[W-1], ext_b_p1} + acc_ext_p1;
        resultado_p1 = satura(soma_p1, sinal_res_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            saida_p2   <= '0;
            estouro_p2 <= 1'b0;
        end else if (avancar) begin
            vld_p2     <= vld_p1;
            saida_p2   <= resultado_p1[LARG_S-1:0];
            estouro_p2 <= resultado_p1[LARG_S];
        end
    end

    // The clear has priority even when a result is being loaded in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
        end else if (limpar_acc) begin
            acc_p2 <= '0;
        end else if (avancar && vld_p1) begin
            acc_p2 <= resultado_p1[LARG_S-1:0];
        end
    end

endmodule

// File: tb/tb_somador_sinal_pipeline.sv
// Scoreboard bench: a clamping and a wrapping instance share all inputs; expected results
// come from an integer model of the arithmetic and are checked in order at the output.
module tb_somador_sinal_pipeline;

    localparam int LA = 8;
    localparam int LB = 4;
    localparam int LS = 8;

    logic          clk;
    logic          rst_n;
    logic          entrada_valida;
    logic [LA-1:0] entrada_a;
    logic [LB-1:0] entrada_b;
    logic [2:0]    codigo;
    logic          limpar_acc;
    logic          saida_pronta;

    logic          entrada_pronta_s, entrada_pronta_w;
    logic [LS-1:0] saida_s, saida_w;
    logic          estouro_s, estouro_w;
    logic          saida_valida_s, saida_valida_w;

    int            n_cmp = 0;
    int            n_err = 0;
    int            modo  = 0;

    logic [LS:0]   fila_s[$];
    logic [LS:0]   fila_w[$];
    int            acc_s = 0;
    int            acc_w = 0;
    bit            parado[2];
    logic [LS:0]   ult[2];

    somador_sinal_pipeline #(.LARG_A(LA), .LARG_B(LB), .LARG_S(LS), .SATURAR(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta_s),
        .entrada_a(entrada_a), .entrada_b(entrada_b), .codigo(codigo), .limpar_acc(limpar_acc),
        .saida(saida_s), .estouro(estouro_s), .saida_valida(saida_valida_s), .saida_pronta(saida_pronta)
    );

    somador_sinal_pipeline #(.LARG_A(LA), .LARG_B(LB), .LARG_S(LS), .SATURAR(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta_w),
        .entrada_a(entrada_a), .entrada_b(entrada_b), .codigo(codigo), .limpar_acc(limpar_acc),
        .saida(saida_w), .estouro(estouro_w), .saida_valida(saida_valida_w), .saida_pronta(saida_pronta)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nome, got, req);
        end
    endtask

    // Integer model: returns {overflow, result bits}.
    function automatic logic [LS:0] modelo(input int a, input int b, input logic [2:0] c,
                                           input int acc, input bit sat);
        int va, vb, vacc, e, lo, hi, r;
        bit sres, ovf;
        va   = (c[0] && a >= 2**(LA-1)) ? a - 2**LA : a;
        vb   = (c[1] && b >= 2**(LB-1)) ? b - 2**LB : b;
        sres = (c[1:0] != 2'b00);
        vacc = (sres && acc >= 2**(LS-1)) ? acc - 2**LS : acc;
        e    = va + vb + (c[2] ? vacc : 0);
        lo   = sres ? -(2**(LS-1)) : 0;
        hi   = sres ? 2**(LS-1) - 1 : 2**LS - 1;
        ovf  = (e < lo) || (e > hi);
        r    = (ovf && sat) ? ((e < lo) ? lo : hi) : e;
        return {ovf, r[LS-1:0]};
    endfunction

    task automatic monitora(input int k, input logic v, input logic [LS-1:0] s, input logic e);
        logic [LS:0] esp;
        string       tag;
        bit          vazia;
        tag   = (k == 0) ? "sat" : "wrap";
        vazia = (k == 0) ? (fila_s.size() == 0) : (fila_w.size() == 0);
        if (v) begin
            if (parado[k]) chk({"estavel_", tag}, {e, s}, ult[k]);
            if (saida_pronta) begin
                if (vazia) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL saida_inesperada_%s: got 0x%0h, required no output", tag, {e, s});
                end else begin
                    if (k == 0) esp = fila_s.pop_front();
                    else        esp = fila_w.pop_front();
                    chk({"resultado_", tag}, {e, s}, esp);
                end
            end
            parado[k] = !saida_pronta;
            ult[k]    = {e, s};
        end else begin
            if (parado[k]) chk({"valida_mantida_", tag}, v, 1'b1);
            parado[k] = 1'b0;
        end
    endtask

    // Monitor first, then capture of newly accepted inputs into the scoreboard.
    always @(negedge clk) begin
        logic [LS:0] r;
        if (!rst_n) begin
            fila_s.delete();
            fila_w.delete();
            acc_s     = 0;
            acc_w     = 0;
            parado[0] = 1'b0;
            parado[1] = 1'b0;
        end else begin
            chk("entrada_pronta_sat", entrada_pronta_s, !saida_valida_s || saida_pronta);
            chk("entrada_pronta_wrap", entrada_pronta_w, !saida_valida_w || saida_pronta);
            monitora(0, saida_valida_s, saida_s, estouro_s);
            monitora(1, saida_valida_w, saida_w, estouro_w);
            if (limpar_acc) begin
                acc_s = 0;
                acc_w = 0;
            end
            if (entrada_valida && entrada_pronta_s) begin
                r = modelo(int'(entrada_a), int'(entrada_b), codigo, acc_s, 1'b1);
                fila_s.push_back(r);
                acc_s = int'(r[LS-1:0]);
                r = modelo(int'(entrada_a), int'(entrada_b), codigo, acc_w, 1'b0);
                fila_w.push_back(r);
                acc_w = int'(r[LS-1:0]);
            end
        end
    end

    // Output-side readiness; a clear is only ever issued while the pipe is advancing.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (modo)
                0:       saida_pronta = 1'b1;
                1:       saida_pronta = limpar_acc || ($urandom_range(0, 3) != 0);
                default: saida_pronta = limpar_acc;
            endcase
        end
    end

    task automatic envia(input logic [LA-1:0] a, input logic [LB-1:0] b, input logic [2:0] c, input bit clr);
        bit ok;
        ok             = 1'b0;
        entrada_valida = 1'b1;
        entrada_a      = a;
        entrada_b      = b;
        codigo         = c;
        limpar_acc     = clr;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (entrada_pronta_s) ok = 1'b1;
            else @(posedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL envia_timeout: got entrada_pronta 0 for 100 cycles, required 1");
        end
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        limpar_acc     = 1'b0;
    endtask

    task automatic pulso_limpar();
        limpar_acc = 1'b1;
        @(posedge clk);
        #1;
        limpar_acc = 1'b0;
    endtask

    task automatic drena();
        bit ok;
        ok   = 1'b0;
        modo = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge clk);
            if (fila_s.size() == 0 && fila_w.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drena_timeout: got %0d results pending, required 0", fila_s.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        entrada_valida = 1'b0;
        entrada_a      = '0;
        entrada_b      = '0;
        codigo         = '0;
        limpar_acc     = 1'b0;
        saida_pronta   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valida", saida_valida_s, 1'b0);
        chk("reset_saida", saida_s, '0);
        chk("reset_estouro", estouro_s, 1'b0);
        chk("reset_pronta", entrada_pronta_s, 1'b1);
        chk("reset_valida_wrap", saida_valida_w, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency from an empty pipe
        envia(8'hF6, 4'h9, 3'b011, 1'b0);
        @(negedge clk);
        chk("latencia_1ciclo", saida_valida_s, 1'b0);
        @(negedge clk);
        chk("latencia_2ciclos", saida_valida_s, 1'b1);
        chk("latencia_saida", saida_s, 8'hEF);
        @(posedge clk);
        #1;

        envia(8'h7F, 4'h1, 3'b011, 1'b0);
        envia(8'd250, 4'd15, 3'b000, 1'b0);
        envia(8'd3, 4'd4, 3'b000, 1'b0);
        envia(8'd200, 4'hC, 3'b010, 1'b0);
        envia(8'd5, 4'hC, 3'b010, 1'b0);
        envia(8'h80, 4'h8, 3'b011, 1'b0);
        drena();

        // Backpressure
        modo = 2;
        @(posedge clk);
        #1;
        envia(8'd1, 4'd1, 3'b000, 1'b0);
        envia(8'd2, 4'd2, 3'b000, 1'b0);
        entrada_valida = 1'b1;
        entrada_a      = 8'd3;
        entrada_b      = 4'd3;
        codigo         = 3'b000;
        repeat (3) @(negedge clk);
        chk("contrapressao_pronta", entrada_pronta_s, 1'b0);
        chk("contrapressao_valida", saida_valida_s, 1'b1);
        chk("contrapressao_saida", saida_s, 8'h02);
        @(posedge clk);
        #1;
        modo = 0;
        envia(8'd3, 4'd3, 3'b000, 1'b0);
        drena();

        // Accumulation with clears, including a clear coinciding with a result load
        pulso_limpar();
        envia(8'd100, 4'd0, 3'b111, 1'b0);
        envia(8'd100, 4'd0, 3'b111, 1'b0);
        envia(8'd100, 4'd0, 3'b111, 1'b0);
        pulso_limpar();
        envia(8'd1, 4'd0, 3'b111, 1'b0);
        envia(8'd250, 4'd10, 3'b100, 1'b0);
        envia(8'd20, 4'd1, 3'b100, 1'b1);
        drena();

        // Asynchronous reset with two transactions in flight
        envia(8'd9, 4'd1, 3'b000, 1'b0);
        envia(8'd8, 4'd2, 3'b000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_voo_valida", saida_valida_s, 1'b0);
        chk("reset_voo_saida", saida_s, '0);
        chk("reset_voo_pronta", entrada_pronta_s, 1'b1);
        chk("reset_voo_valida_wrap", saida_valida_w, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("pos_reset_pronta", entrada_pronta_s, 1'b1);
        chk("pos_reset_valida", saida_valida_s, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure, gaps and clears
        modo = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            envia(LA'($urandom_range(0, 2**LA - 1)), LB'($urandom_range(0, 2**LB - 1)),
                  3'($urandom_range(0, 7)), $urandom_range(0, 11) == 0);
        end
        drena();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
